controller_led_driver: RTL and testbench

- Output-direction counterpart to the player controller input path: drives per-player feedback LEDs on the four controller boards over the same GPIO header.
- Processor-side writes set an 8-bit LED pattern per player; the block serialises all four patterns into a 32-bit frame for daisy-chained 74HC595-style shift registers (serial clock, data, latch).
- Per-player blink masking is supported. Frames are sent automatically whenever displayed content changes.

---
 rtl/controller_led_driver.sv | 110 +++++++++++
 tb/tb_controller_led_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/controller_led_driver.sv
// controller_led_driver: serialises four 8-bit player LED patterns into a 32-bit 74HC595 chain frame,
// resending whenever displayed content changes (writes or blink phase toggles).
module controller_led_driver #(
  parameter int CLK_DIV      = 25,
  parameter int LATCH_CYCLES = 25,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_player,
  input  logic [7:0] wr_data,
  input  logic [3:0] blink_mask,
  output logic       busy,
  output logic       frame_done,
  output logic       sclk,
  output logic       sdata,
  output logic       latch
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;
  localparam logic [31:0] DIV_LAST   = 32'(CLK_DIV - 1);
  localparam logic [31:0] LATCH_LAST = 32'(LATCH_CYCLES - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
  state_t      state_q, state_d;
  logic [7:0]  led_q [4];
  logic [7:0]  led_d [4];
  logic [31:0] blink_cnt_q, blink_cnt_d, cnt_q, cnt_d, word_q, word_d, eff_word;
  logic [4:0]  bit_q, bit_d;
  logic        blink_phase_q, blink_phase_d, dirty_q, dirty_d, sdata_q, sdata_d;
  logic        toggle, set_dirty;
  always_comb begin
    toggle        = blink_cnt_q == BLINK_LAST;
    blink_cnt_d   = toggle ? '0 : blink_cnt_q + 32'd1;
    blink_phase_d = blink_phase_q ^ toggle;
    set_dirty     = wr_en | (toggle & |blink_mask);
    led_d         = led_q;
    if (wr_en) led_d[wr_player] = wr_data;
    eff_word = '0;
    for (int i = 0; i < 4; i++) eff_word[8*i +: 8] = (blink_mask[i] & blink_phase_q) ? 8'h00 : led_q[i];
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    word_d  = word_q;
    bit_d   = bit_q;
    sdata_d = sdata_q;
    dirty_d = dirty_q | set_dirty;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dirty_q) state_d = LOAD;
      end
      LOAD: begin
        word_d  = eff_word;
        bit_d   = 5'd31;
        sdata_d = eff_word[31];
        dirty_d = set_dirty;
        cnt_d   = '0;
        state_d = SHIFT_LO;
      end
      SHIFT_LO: if (cnt_q == DIV_LAST) begin
        cnt_d   = '0;
        state_d = SHIFT_HI;
      end
      SHIFT_HI: if (cnt_q == DIV_LAST) begin
        cnt_d = '0;
        if (bit_q == 5'd0) state_d = LATCH;
        else begin
          // next bit is presented on SHIFT_LO entry so it is set up a full half-period before sclk rises
          bit_d   = bit_q - 5'd1;
          sdata_d = word_q[bit_q - 5'd1];
          state_d = SHIFT_LO;
        end
      end
      LATCH: if (cnt_q == LATCH_LAST) begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      led_q         <= '{default: 8'h00};
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      dirty_q       <= 1'b1;
      cnt_q         <= '0;
      word_q        <= '0;
      bit_q         <= '0;
      sdata_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      led_q         <= led_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      dirty_q       <= dirty_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      bit_q         <= bit_d;
      sdata_q       <= sdata_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign sclk       = state_q == SHIFT_HI;
  assign latch      = state_q == LATCH;
  assign frame_done = (state_q == LATCH) && (cnt_q == LATCH_LAST);
  assign sdata      = sdata_q;
endmodule

// File: tb/tb_controller_led_driver.sv
// tb_controller_led_driver: directed checks of frame content, timing, blinking and reset for controller_led_driver.
module tb_controller_led_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_player = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] blink_mask = '0;
  logic       busy, frame_done, sclk, sdata, latch;

  controller_led_driver #(.CLK_DIV(2), .LATCH_CYCLES(3), .BLINK_DIV(200)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_player(wr_player), .wr_data(wr_data),
    .blink_mask(blink_mask), .busy(busy), .frame_done(frame_done), .sclk(sclk),
    .sdata(sdata), .latch(latch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_frames = 0, bits = 0, busy_cnt = 0, latch_cnt = 0, gap_cnt = 0, cyc = 0;
  int last_gap = 0, last_bits = 0, last_busy = 0, last_latch = 0;
  logic [31:0] cur = '0;
  logic prev_sclk = 1'b0, prev_busy = 1'b0;
  logic [31:0] words[$];
  int done_t[$];

  // observer: reconstructs each frame from sclk rising edges, sampled on the falling clk edge
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      bits = 0; cur = '0; busy_cnt = 0; latch_cnt = 0; gap_cnt = 0;
      prev_sclk = 1'b0; prev_busy = 1'b0;
    end else begin
      if (sclk && !prev_sclk) begin
        cur = {cur[30:0], sdata};
        bits++;
      end
      if (busy && !prev_busy) begin
        last_gap = gap_cnt;
        gap_cnt = 0;
      end
      if (busy) busy_cnt++; else gap_cnt++;
      if (latch) latch_cnt++;
      if (frame_done) begin
        words.push_back(cur);
        done_t.push_back(cyc);
        last_bits = bits; last_busy = busy_cnt; last_latch = latch_cnt;
        bits = 0; busy_cnt = 0; latch_cnt = 0;
        n_frames++;
      end
      prev_sclk = sclk;
      prev_busy = busy;
    end
  end

  typedef struct {
    logic [1:0]  p;
    logic [7:0]  d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] p, input logic [7:0] d);
    wr_player = p; wr_data = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (n_frames < target && k < budget) begin
      step();
      k++;
    end
    check({name, "_frame_timeout"}, 32'(n_frames >= target), 32'd1);
  endtask

  task automatic wait_bits(input string name, input int n);
    int k;
    k = 0;
    while (!(bits == n && sclk) && k < 400) begin
      step();
      k++;
    end
    check({name, "_bit_timeout"}, 32'(bits == n && sclk), 32'd1);
  endtask

  function automatic logic [31:0] wback(input int back);
    return (words.size() > back) ? words[words.size() - 1 - back] : 32'hDEAD_BEEF;
  endfunction

  int n0;

  initial begin
    tbl[0] = '{2'd0, 8'h11, 32'h0000_0011};
    tbl[1] = '{2'd1, 8'h22, 32'h0000_2211};
    tbl[2] = '{2'd2, 8'h33, 32'h0033_2211};
    tbl[3] = '{2'd3, 8'h44, 32'h4433_2211};
    tbl[4] = '{2'd3, 8'h80, 32'h8033_2211};
    tbl[5] = '{2'd0, 8'h01, 32'h8033_2201};

    #2;
    check("rst_sclk", 32'(sclk), 0);
    check("rst_sdata", 32'(sdata), 0);
    check("rst_latch", 32'(latch), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    step(); step();
    rst = 1'b1;

    // post-reset clearing frame
    wait_frames("first", 1, 400);
    check("first_word", wback(0), 32'h0);
    check("first_bits", 32'(last_bits), 32);
    check("first_busy", 32'(last_busy), 132);
    check("first_latch", 32'(last_latch), 3);
    repeat (10) step();
    check("first_idle_busy", 32'(busy), 0);
    check("first_count", 32'(n_frames), 1);

    // p0 write, then p3 write landing in the LOAD cycle
    n0 = n_frames;
    wr(2'd0, 8'hA5);
    step();
    wr(2'd3, 8'h3C);
    wait_frames("pair", n0 + 2, 600);
    check("pair_word_a", wback(1), 32'h0000_00A5);
    check("pair_word_b", wback(0), 32'h3C00_00A5);
    check("pair_gap", 32'(last_gap), 1);
    repeat (300) step();
    check("pair_count", 32'(n_frames), 32'(n0 + 2));

    // write during SHIFT_HI of bit 20 leaves in-flight word alone
    n0 = n_frames;
    wr(2'd2, 8'h00);
    wait_bits("mid", 12);
    wr(2'd1, 8'hFF);
    wait_frames("mid", n0 + 2, 600);
    check("mid_inflight", wback(1), 32'h3C00_00A5);
    check("mid_follow", wback(0), 32'h3C00_FFA5);
    repeat (300) step();
    check("mid_count", 32'(n_frames), 32'(n0 + 2));

    // blinking player 0
    n0 = n_frames;
    blink_mask = 4'b0001;
    wait_frames("blink", n0 + 3, 1000);
    for (int i = 0; i < 3; i++)
      check("blink_word_legal", 32'(wback(i) == 32'h3C00_FFA5 || wback(i) == 32'h3C00_FF00), 1);
    check("blink_alt1", 32'(wback(0) != wback(1)), 1);
    check("blink_alt2", 32'(wback(1) != wback(2)), 1);
    check("blink_period1", 32'(done_t[done_t.size()-1] - done_t[done_t.size()-2]), 200);
    check("blink_period2", 32'(done_t[done_t.size()-2] - done_t[done_t.size()-3]), 200);
    blink_mask = 4'b0000;
    n0 = n_frames;
    repeat (450) step();
    check("blink_off_count", 32'(n_frames), 32'(n0));

    // asynchronous reset at bit 10
    n0 = n_frames;
    wr(2'd2, 8'h00);
    wait_bits("arst", 22);
    check("arst_pre_sclk", 32'(sclk), 1);
    #1 rst = 1'b0;
    #1;
    check("arst_sclk", 32'(sclk), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_latch", 32'(latch), 0);
    check("arst_sdata", 32'(sdata), 0);
    step(); step();
    rst = 1'b1;
    wait_frames("arst", n0 + 1, 400);
    check("arst_word", wback(0), 32'h0);
    check("arst_bits", 32'(last_bits), 32);
    check("arst_busy_len", 32'(last_busy), 132);

    // cumulative single-player writes
    for (int i = 0; i < 6; i++) begin
      repeat (5) step();
      n0 = n_frames;
      wr(tbl[i].p, tbl[i].d);
      wait_frames("tbl", n0 + 1, 400);
      repeat (20) step();
      check($sformatf("tbl%0d_word", i), wback(0), tbl[i].exp);
      check($sformatf("tbl%0d_count", i), 32'(n_frames), 32'(n0 + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
